// File: rtl/comp_fetch_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : comp_fetch_ctrl_if
//  Description : Bundle of the processor fetch port, the compressed-cache
//                lookup and fill ports, the regular icache port and the
//                dictionary lookup ports used by comp_fetch_ctrl.
//                master = controller view, slave = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface comp_fetch_ctrl_if #(
    parameter int K1_W = 3,
    parameter int K2_W = 8,
    parameter int K3_W = 5
);
    localparam int KW = K1_W + K2_W + K3_W;

    // Processor fetch port
    logic          proc_valid;
    logic          proc_ready;
    logic [31:0]   proc_addr;
    logic [31:0]   proc_rdata;

    // Compressed-cache lookup
    logic          cc_valid;
    logic [31:0]   cc_addr;
    logic          cc_ready;
    logic          cc_hit;
    logic [KW-1:0] cc_rdata;

    // Regular icache
    logic          ic_valid;
    logic [31:0]   ic_addr;
    logic          ic_ready;
    logic [31:0]   ic_rdata;

    // Compressed-cache fill
    logic          cc_wr_valid;
    logic [31:0]   cc_wr_addr;
    logic [KW-1:0] cc_wr_data;
    logic          cc_wr_ready;

    // Dictionary: decompress (key -> instruction) and compress (instruction -> key)
    logic [KW-1:0] dict_rd_key;
    logic [31:0]   dict_rd_val;
    logic [31:0]   dict_cmp_val;
    logic [KW-1:0] dict_cmp_key;
    logic [2:0]    dict_cmp_hit;

    modport master (
        input  proc_valid, proc_addr,
        output proc_ready, proc_rdata,
        output cc_valid, cc_addr,
        input  cc_ready, cc_hit, cc_rdata,
        output ic_valid, ic_addr,
        input  ic_ready, ic_rdata,
        output cc_wr_valid, cc_wr_addr, cc_wr_data,
        input  cc_wr_ready,
        output dict_rd_key,
        input  dict_rd_val,
        output dict_cmp_val,
        input  dict_cmp_key, dict_cmp_hit
    );

    modport slave (
        output proc_valid, proc_addr,
        input  proc_ready, proc_rdata,
        input  cc_valid, cc_addr,
        output cc_ready, cc_hit, cc_rdata,
        input  ic_valid, ic_addr,
        output ic_ready, ic_rdata,
        input  cc_wr_valid, cc_wr_addr, cc_wr_data,
        output cc_wr_ready,
        input  dict_rd_key,
        output dict_rd_val,
        input  dict_cmp_val,
        output dict_cmp_key, dict_cmp_hit
    );
endinterface
`default_nettype wire

// File: rtl/comp_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : comp_fetch_ctrl
//  Description : Instruction fetch controller in front of a compressed cache.
//                A fetch first looks up the compressed cache; a hit is
//                expanded through the dictionary, a miss is served by the
//                regular icache. A missed instruction whose three fields all
//                exist in the dictionary is written back in compressed form.
//  Build macro : COMP_CTRL_FILL_EN - when defined, enables the compressed
//                cache write-back (FILL state). When undefined the fill port
//                is tied to zero and every response returns to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_fetch_ctrl #(
    parameter int F1_W = 7,
    parameter int F2_W = 15,
    parameter int K1_W = 3,
    parameter int K2_W = 8,
    parameter int K3_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    comp_fetch_ctrl_if.master bus
);

    localparam int F3_W = 32 - F1_W - F2_W;
    localparam int KW   = K1_W + K2_W + K3_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CC_REQ = 3'd1,
        S_DECOMP = 3'd2,
        S_IC_REQ = 3'd3,
        S_RESP   = 3'd4
`ifdef COMP_CTRL_FILL_EN
        ,
        S_FILL   = 3'd5
`endif
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [31:0]   r_addr;      // address of the fetch in flight
    logic [KW-1:0] r_ckey;      // compressed word returned on a cache hit
    logic [31:0]   r_rdata;     // instruction returned to the processor

    logic          w_accept;
    logic          w_cc_done;
    logic          w_ic_done;

    // Instruction split into its three dictionary fields (field1 in the MSBs)
    logic [F1_W-1:0] w_f1;
    logic [F2_W-1:0] w_f2;
    logic [F3_W-1:0] w_f3;

    assign w_accept  = (r_state == S_IDLE)   && bus.proc_valid;
    assign w_cc_done = (r_state == S_CC_REQ) && bus.cc_ready;
    assign w_ic_done = (r_state == S_IC_REQ) && bus.ic_ready;

    assign w_f1 = bus.ic_rdata[31 -: F1_W];
    assign w_f2 = bus.ic_rdata[F3_W +: F2_W];
    assign w_f3 = bus.ic_rdata[F3_W-1:0];

`ifdef COMP_CTRL_FILL_EN
    logic [KW-1:0] r_wkey;      // compressed form of the missed instruction
    logic          r_cmpok;     // every field of the missed instruction hit
    logic          r_from_ic;   // current response was served by the icache
    logic          w_fill_done;

    assign w_fill_done = (r_state == S_FILL) && bus.cc_wr_ready;
`endif

    // State register; reset returns to IDLE immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; every request state waits for its own ready only
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.proc_valid) begin
                    w_next_state = S_CC_REQ;
                end
            end
            S_CC_REQ: begin
                if (bus.cc_ready) begin
                    w_next_state = bus.cc_hit ? S_DECOMP : S_IC_REQ;
                end
            end
            S_DECOMP: begin
                w_next_state = S_RESP;
            end
            S_IC_REQ: begin
                if (bus.ic_ready) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
`ifdef COMP_CTRL_FILL_EN
                // Only icache-served instructions are worth writing back
                w_next_state = (r_cmpok && r_from_ic) ? S_FILL : S_IDLE;
`else
                w_next_state = S_IDLE;
`endif
            end
`ifdef COMP_CTRL_FILL_EN
            S_FILL: begin
                if (bus.cc_wr_ready) begin
                    w_next_state = S_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Transaction datapath: address, compressed word and returned instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_ckey  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.proc_addr;
            end
            if (w_cc_done && bus.cc_hit) begin
                r_ckey <= bus.cc_rdata;
            end
            // proc_rdata only changes on the cycle that leads into RESP
            if (r_state == S_DECOMP) begin
                r_rdata <= bus.dict_rd_val;
            end else if (w_ic_done) begin
                r_rdata <= bus.ic_rdata;
            end
        end
    end

`ifdef COMP_CTRL_FILL_EN
    // Write-back bookkeeping captured when the icache answers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wkey    <= '0;
            r_cmpok   <= 1'b0;
            r_from_ic <= 1'b0;
        end else begin
            if (w_accept) begin
                // A new fetch must not inherit a stale write-back decision
                r_cmpok   <= 1'b0;
                r_from_ic <= 1'b0;
            end else if (w_ic_done) begin
                r_wkey    <= bus.dict_cmp_key;
                r_cmpok   <= &bus.dict_cmp_hit;
                r_from_ic <= 1'b1;
            end
        end
    end

    assign bus.cc_wr_valid = (r_state == S_FILL);
    assign bus.cc_wr_addr  = (r_state == S_FILL) ? r_addr : '0;
    assign bus.cc_wr_data  = (r_state == S_FILL) ? r_wkey : '0;
`else
    // The compress result and fill handshake have no consumer in this build
    logic w_unused_fill_inputs;
    assign w_unused_fill_inputs = ^{bus.dict_cmp_key, bus.dict_cmp_hit, bus.cc_wr_ready};

    assign bus.cc_wr_valid = 1'b0;
    assign bus.cc_wr_addr  = '0;
    assign bus.cc_wr_data  = '0;
`endif

    // Request outputs are decoded from state so they drop with reset at once
    assign bus.proc_ready   = (r_state == S_RESP);
    assign bus.proc_rdata   = r_rdata;
    assign bus.cc_valid     = (r_state == S_CC_REQ);
    assign bus.cc_addr      = (r_state == S_CC_REQ) ? r_addr : '0;
    assign bus.ic_valid     = (r_state == S_IC_REQ);
    assign bus.ic_addr      = (r_state == S_IC_REQ) ? r_addr : '0;
    assign bus.dict_rd_key  = (r_state == S_DECOMP) ? r_ckey : '0;
    assign bus.dict_cmp_val = (r_state == S_IC_REQ) ? {w_f1, w_f2, w_f3} : '0;

endmodule
`default_nettype wire

// File: tb/tb_comp_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_comp_fetch_ctrl
//  Description : Self-checking bench for comp_fetch_ctrl: directed vector
//                table, multi-cycle reset / back-to-back sequences and
//                randomized transactions against a transaction-level model.
//  Build macro : COMP_CTRL_FILL_EN (selects fill expectations)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_fetch_ctrl;

`ifdef COMP_CTRL_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    comp_fetch_ctrl_if bif ();

    comp_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // Dictionary contents seen by the decompress port
    function automatic logic [31:0] dict_fn(input logic [15:0] k);
        if (k == 16'h1234) return 32'h00A00513;
        return {k ^ 16'h5A5A, k};
    endfunction

    logic [15:0] cmp_key_v;
    logic [2:0]  cmp_hit_v;
    assign bif.dict_cmp_key = cmp_key_v;
    assign bif.dict_cmp_hit = cmp_hit_v;
    always_comb bif.dict_rd_val = dict_fn(bif.dict_rd_key);

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [15:0] cword;
        logic [31:0] icdata;
        logic [15:0] ckey;
        logic [2:0]  chit;
        int          ccd;
        int          icd;
        int          wrd;
        bit          hold;
        bit          noise;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_ic_cyc;
        bit          exp_fill;
        logic [15:0] exp_fill_data;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] prev_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bif.proc_valid  = 1'b0;
        bif.proc_addr   = '0;
        bif.cc_ready    = 1'b0;
        bif.cc_hit      = 1'b0;
        bif.cc_rdata    = '0;
        bif.ic_ready    = 1'b0;
        bif.ic_rdata    = '0;
        bif.cc_wr_ready = 1'b0;
        cmp_key_v       = '0;
        cmp_hit_v       = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_rdata = '0;
    endtask

    // Transaction-level expectations straight from the protocol rules
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_lat       = (v.ccd + 1) + (v.hit ? 1 : v.icd + 1) + 1;
        r.exp_rdata     = v.hit ? dict_fn(v.cword) : v.icdata;
        r.exp_ic_cyc    = v.hit ? 0 : v.icd + 1;
        r.exp_fill      = !v.hit && (v.chit == 3'b111);
        r.exp_fill_data = v.ckey;
        return r;
    endfunction

    // Drive one fetch with a responding environment and check what it saw
    task automatic run_txn(input vec_t v, input string tag);
        int c, lat, nready, cc_cyc, ic_cyc, wr_cyc, rd_cyc, stab_bad, hold_bad, spur, exp_wr;
        bit done;
        logic [31:0] rdata, f_addr;
        logic [15:0] f_data, rd_key;
        c = 0; lat = -1; nready = 0; cc_cyc = 0; ic_cyc = 0; wr_cyc = 0; rd_cyc = 0;
        stab_bad = 0; hold_bad = 0; spur = 0; done = 1'b0;
        rdata = '0; f_addr = '0; f_data = '0; rd_key = '0;
        exp_wr = (v.exp_fill && FILL_EN) ? v.wrd + 1 : 0;

        @(negedge clk);
        bif.proc_valid  = 1'b1;
        bif.proc_addr   = v.addr;
        bif.cc_hit      = v.hit;
        bif.cc_rdata    = v.cword;
        bif.ic_rdata    = v.icdata;
        bif.cc_ready    = 1'b0;
        bif.ic_ready    = 1'b0;
        bif.cc_wr_ready = 1'b0;
        cmp_key_v       = v.ckey;
        cmp_hit_v       = v.chit;

        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            if (bif.proc_ready) begin
                nready++;
                if (nready == 1) begin
                    lat   = c;
                    rdata = bif.proc_rdata;
                end
            end else if (nready == 0 && bif.proc_rdata !== prev_rdata) begin
                hold_bad++;
            end
            if (bif.cc_valid) begin
                cc_cyc++;
                if (bif.cc_addr !== v.addr) stab_bad++;
            end
            if (bif.ic_valid) begin
                ic_cyc++;
                if (bif.ic_addr !== v.addr || bif.dict_cmp_val !== v.icdata) stab_bad++;
            end
            if (bif.cc_wr_valid) begin
                wr_cyc++;
                if (wr_cyc == 1) begin
                    f_addr = bif.cc_wr_addr;
                    f_data = bif.cc_wr_data;
                end else if (bif.cc_wr_addr !== f_addr || bif.cc_wr_data !== f_data) begin
                    stab_bad++;
                end
            end
            if (bif.dict_rd_key != '0) begin
                rd_cyc++;
                rd_key = bif.dict_rd_key;
            end
            bif.proc_valid  = v.hold && (nready == 0);
            bif.cc_ready    = bif.cc_valid ? (cc_cyc > v.ccd)
                                           : (v.noise && $urandom_range(0, 1) == 1);
            bif.ic_ready    = bif.ic_valid ? (ic_cyc > v.icd)
                                           : (v.noise && $urandom_range(0, 1) == 1);
            bif.cc_wr_ready = bif.cc_wr_valid ? (wr_cyc > v.wrd)
                                              : (v.noise && $urandom_range(0, 1) == 1);
            done = (nready > 0) && (c > lat) && !bif.cc_wr_valid;
        end

        chk({tag, ".complete"}, 32'(done), 32'd1);
        bif.proc_valid  = 1'b0;
        bif.cc_ready    = 1'b0;
        bif.ic_ready    = 1'b0;
        bif.cc_wr_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bif.cc_valid || bif.ic_valid || bif.cc_wr_valid || bif.proc_ready) spur++;
            if (bif.proc_rdata !== v.exp_rdata) hold_bad++;
        end

        chk({tag, ".latency"}, lat, v.exp_lat);
        chk({tag, ".rdata"}, rdata, v.exp_rdata);
        chk({tag, ".ready_pulses"}, nready, 1);
        chk({tag, ".cc_cycles"}, cc_cyc, v.ccd + 1);
        chk({tag, ".ic_cycles"}, ic_cyc, v.exp_ic_cyc);
        chk({tag, ".fill_cycles"}, wr_cyc, exp_wr);
        if (exp_wr > 0) begin
            chk({tag, ".fill_addr"}, f_addr, v.addr);
            chk({tag, ".fill_data"}, f_data, v.exp_fill_data);
        end
        chk({tag, ".decomp_cycles"}, rd_cyc, v.hit ? 1 : 0);
        if (v.hit) chk({tag, ".decomp_key"}, rd_key, v.cword);
        chk({tag, ".stable"}, stab_bad, 0);
        chk({tag, ".rdata_hold"}, hold_bad, 0);
        chk({tag, ".spurious"}, spur, 0);
        prev_rdata = v.exp_rdata;
    endtask

    // Reset in the middle of an icache wait, then accept on the first edge
    task automatic seq_reset_in_ic();
        @(negedge clk);
        bif.proc_valid = 1'b1;
        bif.proc_addr  = 32'h0000_0800;
        bif.cc_hit     = 1'b0;
        bif.ic_rdata   = 32'hCAFE_F00D;
        bif.cc_ready   = 1'b1;
        @(negedge clk);
        bif.proc_valid = 1'b0;
        @(negedge clk);
        bif.cc_ready = 1'b0;
        chk("rst_ic.in_ic_req", bif.ic_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_ic.ic_valid", bif.ic_valid, 1'b0);
        chk("rst_ic.ic_addr", bif.ic_addr, 32'h0);
        chk("rst_ic.dict_cmp_val", bif.dict_cmp_val, 32'h0);
        chk("rst_ic.proc_rdata", bif.proc_rdata, 32'h0);
        chk("rst_ic.other_valids", {bif.proc_ready, bif.cc_valid, bif.cc_wr_valid}, 3'b000);
        chk("rst_ic.other_addrs", bif.cc_addr | bif.cc_wr_addr, 32'h0);
        chk("rst_ic.keys", {bif.cc_wr_data, bif.dict_rd_key}, 32'h0);
        @(negedge clk);
        idle_inputs();
        bif.proc_valid = 1'b1;
        bif.proc_addr  = 32'h0000_0900;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ic.first_accept", bif.cc_valid, 1'b1);
        chk("rst_ic.first_addr", bif.cc_addr, 32'h0000_0900);
        do_reset();
    endtask

    // A second request held through RESP/FILL is only taken once IDLE
    task automatic seq_back_to_back();
        int c, last1, first2, wr_cyc, nready;
        c = 0; last1 = -1; first2 = -1; wr_cyc = 0; nready = 0;
        @(negedge clk);
        bif.proc_valid = 1'b1;
        bif.proc_addr  = 32'h0000_0600;
        bif.cc_hit     = 1'b0;
        bif.ic_rdata   = 32'h0010_0093;
        cmp_key_v      = 16'h0555;
        cmp_hit_v      = 3'b111;
        while (first2 < 0 && c < 100) begin
            @(negedge clk);
            c++;
            if (bif.cc_valid && bif.cc_addr == 32'h0000_0700) first2 = c;
            else if (bif.cc_valid || bif.ic_valid || bif.proc_ready || bif.cc_wr_valid) last1 = c;
            if (bif.proc_ready) begin
                nready++;
                bif.proc_addr = 32'h0000_0700;
            end
            if (bif.cc_wr_valid) wr_cyc++;
            bif.cc_ready    = bif.cc_valid;
            bif.ic_ready    = bif.ic_valid;
            bif.cc_wr_ready = bif.cc_wr_valid && (wr_cyc > 3);
        end
        chk("b2b.second_accept_cycle", first2, FILL_EN ? 9 : 5);
        chk("b2b.idle_gap", first2 - last1, 2);
        chk("b2b.ready_pulses", nready, 1);
        chk("b2b.fill_cycles", wr_cyc, FILL_EN ? 4 : 0);
        do_reset();
    endtask

    vec_t vecs[6];

    initial begin
        // addr, hit, cword, icdata, ckey, chit, ccd, icd, wrd, hold, noise,
        // exp_lat, exp_rdata, exp_ic_cyc, exp_fill, exp_fill_data
        vecs[0] = '{32'h0000_0100, 1'b1, 16'h1234, 32'hDEAD_BEEF, 16'h0000, 3'b000, 0, 0, 0, 1'b1, 1'b0,
                    3,  32'h00A0_0513, 0, 1'b0, 16'h0000};
        vecs[1] = '{32'h0000_0200, 1'b0, 16'h0001, 32'h0000_0013, 16'h0ABC, 3'b111, 0, 0, 2, 1'b0, 1'b0,
                    3,  32'h0000_0013, 1, 1'b1, 16'h0ABC};
        vecs[2] = '{32'h0000_0300, 1'b0, 16'h0002, 32'h00B0_0593, 16'h0123, 3'b101, 0, 0, 0, 1'b1, 1'b1,
                    3,  32'h00B0_0593, 1, 1'b0, 16'h0000};
        vecs[3] = '{32'h0000_0400, 1'b0, 16'h0003, 32'h1234_5678, 16'h7FFF, 3'b111, 4, 6, 3, 1'b1, 1'b1,
                    13, 32'h1234_5678, 7, 1'b1, 16'h7FFF};
        vecs[4] = '{32'h0000_0500, 1'b1, 16'hBEEF, 32'h0000_0000, 16'h1111, 3'b111, 4, 0, 0, 1'b0, 1'b1,
                    7,  32'hE4B5_BEEF, 0, 1'b0, 16'h0000};
        vecs[5] = '{32'hFFFF_FFFC, 1'b0, 16'h0004, 32'hFFFF_FFFF, 16'hFFFF, 3'b011, 1, 2, 0, 1'b0, 1'b0,
                    6,  32'hFFFF_FFFF, 3, 1'b0, 16'h0000};

        idle_inputs();
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset.valids", {bif.proc_ready, bif.cc_valid, bif.ic_valid, bif.cc_wr_valid}, 4'b0000);
        chk("reset.proc_rdata", bif.proc_rdata, 32'h0);
        chk("reset.addrs", bif.cc_addr | bif.ic_addr | bif.cc_wr_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset.idle", {bif.proc_ready, bif.cc_valid, bif.ic_valid, bif.cc_wr_valid}, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        seq_reset_in_ic();
        seq_back_to_back();

        for (int i = 0; i < 40; i++) begin
            vec_t r;
            r.addr   = $urandom;
            r.hit    = ($urandom_range(0, 1) == 1);
            r.cword  = 16'($urandom_range(1, 16'hFFFF));
            r.icdata = $urandom;
            r.ckey   = 16'($urandom);
            r.chit   = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 6));
            r.ccd    = $urandom_range(0, 3);
            r.icd    = $urandom_range(0, 3);
            r.wrd    = $urandom_range(0, 3);
            r.hold   = ($urandom_range(0, 1) == 1);
            r.noise  = ($urandom_range(0, 1) == 1);
            r = model(r);
            run_txn(r, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
